// File: rtl/accum_fsm_multi.sv
// Multi-channel accumulator with a three-state sequencer.
// Define ACCUM_SATURATE_EN to clamp results on overflow/underflow instead of wrapping.
module accum_fsm_multi #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int LED_W    = 8,
    parameter  int LED_LSB  = 16,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic [WIDTH-1:0]    in_value,
    input  logic                in_op,
    input  logic [CW-1:0]       disp_chan,
    output logic [LED_W-1:0]    led,
    output logic                out_valid,
    output logic [CW-1:0]       out_chan,
    output logic [WIDTH-1:0]    out_sum,
    output logic [CHANNELS-1:0] ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    localparam logic [CW:0] CHAN_LIMIT = (CW+1)'(CHANNELS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_block;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_exec;

    logic [WIDTH-1:0]      r_acc [CHANNELS];
    logic [CHANNELS-1:0]   r_ovf;
    logic [CW-1:0]         r_cmd_chan;
    logic [WIDTH-1:0]      r_cmd_value;
    logic                  r_cmd_op;
    logic [WIDTH-1:0]      r_operand;
    logic                  r_out_valid;
    logic [CW-1:0]         r_out_chan;
    logic [WIDTH-1:0]      r_out_sum;

    logic                  w_cmd_chan_ok;
    logic                  w_disp_chan_ok;
    logic [WIDTH-1:0]      w_acc_rd;
    logic [WIDTH:0]        w_ext;
    logic                  w_flow;
    logic [WIDTH-1:0]      w_result;

    // Reset and clear both abort whatever the sequencer is doing.
    assign w_block = RST | clear;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (w_block) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idle      = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (in_valid && !w_block) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready = w_idle & ~w_block;

    // Out-of-range channels (non power-of-two CHANNELS) read as zero and never write.
    assign w_cmd_chan_ok  = ({1'b0, r_cmd_chan} < CHAN_LIMIT);
    assign w_disp_chan_ok = ({1'b0, disp_chan} < CHAN_LIMIT);
    assign w_acc_rd       = w_cmd_chan_ok ? r_acc[r_cmd_chan] : '0;

    // The extra top bit carries out on add and goes high on borrow for subtract.
    always_comb begin
        if (r_cmd_op) begin
            w_ext = {1'b0, r_operand} - {1'b0, r_cmd_value};
        end else begin
            w_ext = {1'b0, r_operand} + {1'b0, r_cmd_value};
        end
        w_flow   = w_ext[WIDTH];
        w_result = w_ext[WIDTH-1:0];
`ifdef ACCUM_SATURATE_EN
        if (w_flow) begin
            w_result = r_cmd_op ? '0 : '1;
        end
`endif
    end

    // NOTE: the accumulator array is reset because clear/RST must leave every channel at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_sum   <= '0;
            r_cmd_chan  <= '0;
            r_cmd_value <= '0;
            r_cmd_op    <= 1'b0;
            r_operand   <= '0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_cmd_chan  <= in_chan;
                r_cmd_value <= in_value;
                r_cmd_op    <= in_op;
            end
            if (w_load) begin
                r_operand <= w_acc_rd;
            end
            if (w_exec && w_cmd_chan_ok) begin
                r_acc[r_cmd_chan] <= w_result;
                if (w_flow) begin
                    r_ovf[r_cmd_chan] <= 1'b1;
                end
                r_out_valid <= 1'b1;
                r_out_chan  <= r_cmd_chan;
                r_out_sum   <= w_result;
            end
        end
    end

    always_comb begin
        led = '0;
        if (w_disp_chan_ok) begin
            led = r_acc[disp_chan][LED_LSB +: LED_W];
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_sum   = r_out_sum;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_accum_fsm_multi.sv
// Bench for accum_fsm_multi: default-size instance plus an 8-bit, 3-channel instance.
// Honours ACCUM_SATURATE_EN so expectations follow the build under test.
module tb_accum_fsm_multi;

`ifdef ACCUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLK;
    logic RST;
    logic clear;

    logic        a_in_valid, a_in_ready, a_in_op, a_out_valid;
    logic [1:0]  a_in_chan, a_disp_chan, a_out_chan;
    logic [31:0] a_in_value, a_out_sum;
    logic [7:0]  a_led;
    logic [3:0]  a_ovf;

    logic        b_in_valid, b_in_ready, b_in_op, b_out_valid;
    logic [1:0]  b_in_chan, b_disp_chan, b_out_chan;
    logic [7:0]  b_in_value, b_out_sum, b_led;
    logic [2:0]  b_ovf;

    accum_fsm_multi dut_a (
        .CLK(CLK), .RST(RST), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_chan(a_in_chan),
        .in_value(a_in_value), .in_op(a_in_op), .disp_chan(a_disp_chan),
        .led(a_led), .out_valid(a_out_valid), .out_chan(a_out_chan),
        .out_sum(a_out_sum), .ovf(a_ovf)
    );

    accum_fsm_multi #(.WIDTH(8), .CHANNELS(3), .LED_W(8), .LED_LSB(0)) dut_b (
        .CLK(CLK), .RST(RST), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_chan(b_in_chan),
        .in_value(b_in_value), .in_op(b_in_op), .disp_chan(b_disp_chan),
        .led(b_led), .out_valid(b_out_valid), .out_chan(b_out_chan),
        .out_sum(b_out_sum), .ovf(b_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model for the 32-bit, 4-channel instance.
    longint unsigned m_acc [4];
    bit [3:0]        m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_ovf = '0;
    endtask

    task automatic model_apply(input int chan, input longint unsigned val, input bit op,
                               output longint unsigned res);
        longint unsigned max_v = 64'hFFFF_FFFF;
        if (!op) begin
            if (m_acc[chan] + val > max_v) begin
                m_ovf[chan] = 1'b1;
                res = SAT ? max_v : m_acc[chan] + val - (max_v + 1);
            end else begin
                res = m_acc[chan] + val;
            end
        end else begin
            if (val > m_acc[chan]) begin
                m_ovf[chan] = 1'b1;
                res = SAT ? 64'd0 : m_acc[chan] + (max_v + 1) - val;
            end else begin
                res = m_acc[chan] - val;
            end
        end
        m_acc[chan] = res;
    endtask

    // Issue one command and return when out_valid is seen (or the budget expires).
    task automatic send_a(input logic [1:0] chan, input logic [31:0] val, input logic op,
                          output int lat);
        int waited = 0;
        a_in_chan  = chan;
        a_in_value = val;
        a_in_op    = op;
        a_in_valid = 1'b1;
        while (!a_in_ready && waited < 10) begin
            step();
            waited++;
        end
        if (!a_in_ready) check("a_ready_timeout", 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic send_b(input logic [1:0] chan, input logic [7:0] val, input logic op,
                          output int lat);
        int waited = 0;
        b_in_chan  = chan;
        b_in_value = val;
        b_in_op    = op;
        b_in_valid = 1'b1;
        while (!b_in_ready && waited < 10) begin
            step();
            waited++;
        end
        if (!b_in_ready) check("b_ready_timeout", 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] value;
        logic        op;
        logic [1:0]  disp;
        logic [31:0] exp_sum;
        logic [3:0]  exp_ovf;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int              lat;
        logic [1:0]      ch, d;
        logic [31:0]     v;
        logic            op;
        longint unsigned e;

        vecs[0] = '{2'd1, 32'h0001_0000, 1'b0, 2'd1, 32'h0001_0000, 4'h0, 8'h01};
        vecs[1] = '{2'd1, 32'h0001_0000, 1'b0, 2'd1, 32'h0002_0000, 4'h0, 8'h02};
        vecs[2] = '{2'd1, 32'h0001_0000, 1'b0, 2'd1, 32'h0003_0000, 4'h0, 8'h03};
        vecs[3] = '{2'd0, 32'd5,         1'b0, 2'd0, 32'd5,         4'h0, 8'h00};
        vecs[4] = '{2'd2, 32'd7,         1'b0, 2'd2, 32'd7,         4'h0, 8'h00};
        vecs[5] = '{2'd0, 32'd2,         1'b1, 2'd1, 32'd3,         4'h0, 8'h03};
        vecs[6] = '{2'd0, 32'd0,         1'b0, 2'd0, 32'd3,         4'h0, 8'h00};
        vecs[7] = '{2'd2, 32'd0,         1'b0, 2'd2, 32'd7,         4'h0, 8'h00};
        vecs[8] = '{2'd3, 32'd0,         1'b0, 2'd3, 32'd0,         4'h0, 8'h00};
        vecs[9] = '{2'd3, 32'd1,         1'b1, 2'd3,
                    SAT ? 32'd0 : 32'hFFFF_FFFF, 4'h8, SAT ? 8'h00 : 8'hFF};

        RST = 1'b1;
        clear = 1'b0;
        a_in_valid = 1'b0; a_in_chan = '0; a_in_value = '0; a_in_op = 1'b0; a_disp_chan = '0;
        b_in_valid = 1'b0; b_in_chan = '0; b_in_value = '0; b_in_op = 1'b0; b_disp_chan = '0;

        // Reset state
        step(); step(); step();
        check("a_ready_in_rst", 64'(a_in_ready), 64'd0);
        check("b_ready_in_rst", 64'(b_in_ready), 64'd0);
        RST = 1'b0;
        #1;
        check("a_ready_after_rst", 64'(a_in_ready), 64'd1);
        check("a_out_valid_rst", 64'(a_out_valid), 64'd0);
        check("a_out_chan_rst", 64'(a_out_chan), 64'd0);
        check("a_out_sum_rst", 64'(a_out_sum), 64'd0);
        check("a_ovf_rst", 64'(a_ovf), 64'd0);
        check("a_led_rst", 64'(a_led), 64'd0);
        check("b_ovf_rst", 64'(b_ovf), 64'd0);

        // Directed vectors: accumulate, channel isolation, underflow
        for (int i = 0; i < 10; i++) begin
            a_disp_chan = vecs[i].disp;
            send_a(vecs[i].chan, vecs[i].value, vecs[i].op, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("vec%0d_out_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("vec%0d_out_chan", i), 64'(a_out_chan), 64'(vecs[i].chan));
            check($sformatf("vec%0d_out_sum", i), 64'(a_out_sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_ovf", i), 64'(a_ovf), 64'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_led", i), 64'(a_led), 64'(vecs[i].exp_led));
            check($sformatf("vec%0d_ready", i), 64'(a_in_ready), 64'd1);
            step();
            check($sformatf("vec%0d_pulse_end", i), 64'(a_out_valid), 64'd0);
            check($sformatf("vec%0d_sum_hold", i), 64'(a_out_sum), 64'(vecs[i].exp_sum));
        end

        // Clear while the command sits in EXEC, with in_valid held throughout
        a_disp_chan = 2'd1;
        a_in_chan = 2'd1; a_in_value = 32'd1; a_in_op = 1'b0; a_in_valid = 1'b1;
        step();
        check("clr_ready_in_load", 64'(a_in_ready), 64'd0);
        step();
        clear = 1'b1;
        #1;
        check("clr_ready_during_clear", 64'(a_in_ready), 64'd0);
        step();
        check("clr_no_out_valid", 64'(a_out_valid), 64'd0);
        check("clr_ovf_zero", 64'(a_ovf), 64'd0);
        check("clr_led_zero", 64'(a_led), 64'd0);
        clear = 1'b0;
        #1;
        check("clr_ready_back", 64'(a_in_ready), 64'd1);
        step();
        a_in_valid = 1'b0;
        step(); step();
        check("clr_next_cmd_valid", 64'(a_out_valid), 64'd1);
        check("clr_next_cmd_sum", 64'(a_out_sum), 64'd1);
        model_reset();
        m_acc[1] = 1;
        for (int c = 0; c < 4; c++) begin
            if (c != 1) begin
                send_a(2'(c), 32'd0, 1'b0, lat);
                check($sformatf("clr_ch%0d_zero", c), 64'(a_out_sum), 64'd0);
            end
        end

        // Randomised back-to-back commands against the model
        for (int i = 0; i < 60; i++) begin
            ch = 2'($urandom_range(0, 3));
            d  = 2'($urandom_range(0, 3));
            op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       v = 32'($urandom_range(0, 1000));
                1:       v = $urandom();
                default: v = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            endcase
            a_disp_chan = d;
            send_a(ch, v, op, lat);
            model_apply(int'(ch), longint'(v), op, e);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("rnd%0d_out_chan", i), 64'(a_out_chan), 64'(ch));
            check($sformatf("rnd%0d_out_sum", i), 64'(a_out_sum), 64'(e));
            check($sformatf("rnd%0d_ovf", i), 64'(a_ovf), 64'(m_ovf));
            check($sformatf("rnd%0d_led", i), 64'(a_led), (m_acc[d] >> 16) & 64'hFF);
        end

        // 8-bit instance: wrap or saturate on ch0
        b_disp_chan = 2'd0;
        send_b(2'd0, 8'd250, 1'b0, lat);
        check("b_add250_latency", 64'(lat), 64'd3);
        check("b_add250_sum", 64'(b_out_sum), 64'd250);
        check("b_add250_ovf", 64'(b_ovf), 64'd0);
        send_b(2'd0, 8'd10, 1'b0, lat);
        check("b_add10_sum", 64'(b_out_sum), SAT ? 64'd255 : 64'd4);
        check("b_add10_ovf", 64'(b_ovf), 64'd1);
        check("b_add10_led", 64'(b_led), SAT ? 64'd255 : 64'd4);

        // Invalid channel on the 3-channel instance
        b_in_chan = 2'd3; b_in_value = 8'd9; b_in_op = 1'b0; b_in_valid = 1'b1;
        #1;
        check("b_inv_ready_before", 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0;
        check("b_inv_accepted", 64'(b_in_ready), 64'd0);
        step();
        check("b_inv_ready_e1", 64'(b_in_ready), 64'd0);
        check("b_inv_no_valid_e1", 64'(b_out_valid), 64'd0);
        step();
        check("b_inv_ready_e2", 64'(b_in_ready), 64'd1);
        check("b_inv_no_valid_e2", 64'(b_out_valid), 64'd0);
        step();
        check("b_inv_no_valid_e3", 64'(b_out_valid), 64'd0);
        check("b_inv_ovf_kept", 64'(b_ovf), 64'd1);
        check("b_inv_led_kept", 64'(b_led), SAT ? 64'd255 : 64'd4);
        send_b(2'd1, 8'd0, 1'b0, lat);
        check("b_inv_ch1_zero", 64'(b_out_sum), 64'd0);
        send_b(2'd2, 8'd0, 1'b0, lat);
        check("b_inv_ch2_zero", 64'(b_out_sum), 64'd0);
        check("b_inv_ch2_chan", 64'(b_out_chan), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
